// File: rtl/vram_pkg.sv
// Shared types for the video RAM arbiter: access owner, return-path tag and
// default bus widths.
package vram_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 9;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VGA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the CPU/VGA requesters, the arbiter and the RAM port.
// The slave view belongs to the arbiter; master is everything around it.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_q,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           ram_address, ram_wren, ram_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_q,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           ram_address, ram_wren, ram_data
  );

endinterface

// File: rtl/vram_tag_pipe.sv
// Shift register of {valid, owner} tags that follows each RAM access until its
// read data is due. pre_out is the stage whose data is on ram_q right now.
module vram_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic clear,
  input  tag_t push,
  output tag_t pre_out,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stage_reg;

  always_ff @(posedge clock) begin
    if (clear) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[DEPTH-2:0], push};
    end
  end

  assign pre_out = stage_reg[DEPTH-2];
  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// One-access-per-clock arbiter for the video RAM: VGA has priority, the CPU
// wins after CPU_MAX_WAIT consecutive denials; read data is routed by tag.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int RD_LAT       = 1,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  localparam int WAIT_W = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              force_cpu, cpu_gnt, vga_gnt;
  logic [ADDR_W-1:0] ram_address_reg, ram_address_next;
  logic              ram_wren_reg, ram_wren_next;
  logic [DATA_W-1:0] ram_data_reg, ram_data_next;
  logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
  logic [DATA_W-1:0] vga_rdata_reg, vga_rdata_next;
  tag_t              tag_push, tag_pre, tag_out;

  always_comb begin
    force_cpu = (wait_cnt_reg == WAIT_MAX);
    cpu_gnt   = ~reset & bus.cpu_req & (~bus.vga_req | force_cpu);
    vga_gnt   = ~reset & bus.vga_req & ~cpu_gnt;
  end

  // Counts consecutive denied CPU cycles; a dropped request forgets the wait.
  always_comb begin
    wait_cnt_next = '0;
    if (bus.cpu_req && !cpu_gnt) begin
      wait_cnt_next = force_cpu ? wait_cnt_reg : wait_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    ram_address_next = ram_address_reg;
    ram_wren_next    = 1'b0;
    ram_data_next    = ram_data_reg;
    tag_push         = '{valid: 1'b0, owner: OWN_CPU};
    if (cpu_gnt) begin
      ram_address_next = bus.cpu_addr;
      ram_wren_next    = bus.cpu_we;
      ram_data_next    = bus.cpu_wdata;
      tag_push         = '{valid: ~bus.cpu_we, owner: OWN_CPU};
    end else if (vga_gnt) begin
      ram_address_next = bus.vga_addr;
      tag_push         = '{valid: 1'b1, owner: OWN_VGA};
    end
  end

  // Capture ram_q on the same edge the tag reaches the last stage, so rdata
  // and rvalid appear together.
  always_comb begin
    cpu_rdata_next = cpu_rdata_reg;
    vga_rdata_next = vga_rdata_reg;
    if (tag_pre.valid) begin
      if (tag_pre.owner == OWN_CPU) begin
        cpu_rdata_next = bus.ram_q;
      end else begin
        vga_rdata_next = bus.ram_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_reg    <= '0;
      ram_address_reg <= '0;
      ram_wren_reg    <= 1'b0;
      ram_data_reg    <= '0;
      cpu_rdata_reg   <= '0;
      vga_rdata_reg   <= '0;
    end else begin
      wait_cnt_reg    <= wait_cnt_next;
      ram_address_reg <= ram_address_next;
      ram_wren_reg    <= ram_wren_next;
      ram_data_reg    <= ram_data_next;
      cpu_rdata_reg   <= cpu_rdata_next;
      vga_rdata_reg   <= vga_rdata_next;
    end
  end

  vram_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clock   (clock),
    .clear   (reset),
    .push    (tag_push),
    .pre_out (tag_pre),
    .tag_out (tag_out)
  );

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.vga_gnt     = vga_gnt;
  assign bus.cpu_rvalid  = tag_out.valid & (tag_out.owner == OWN_CPU);
  assign bus.vga_rvalid  = tag_out.valid & (tag_out.owner == OWN_VGA);
  assign bus.cpu_rdata   = cpu_rdata_reg;
  assign bus.vga_rdata   = vga_rdata_reg;
  assign bus.ram_address = ram_address_reg;
  assign bus.ram_wren    = ram_wren_reg;
  assign bus.ram_data    = ram_data_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model plus a transaction-level reference model
// (shadow memory and a queue of expected read returns) checked every cycle.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 9;
  localparam int RD_LAT       = 1;   // the RAM model below is combinational past ram_address
  localparam int CPU_MAX_WAIT = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RD_LAT       (RD_LAT),
    .CPU_MAX_WAIT (CPU_MAX_WAIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM: registered write, read of the registered address with new-data RDW.
  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
  always @(posedge clock) if (bus.ram_wren) ram_mem[bus.ram_address] = bus.ram_data;
  assign bus.ram_q = ram_mem[bus.ram_address];

  typedef struct {
    int                due;
    owner_e            owner;
    logic [DATA_W-1:0] data;
  } rd_t;

  typedef struct {
    bit                cpu_req;
    bit                cpu_we;
    bit                vga_req;
    logic [DATA_W-1:0] wdata;
    bit                e_cpu;
    bit                e_vga;
  } vec_t;

  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  rd_t               rd_q[$];
  int                cyc, denied;
  bit                m_cpu, m_vga;
  logic [ADDR_W-1:0] e_addr;
  logic              e_wren;
  logic [DATA_W-1:0] e_wdata, e_cpu_rdata, e_vga_rdata;

  logic              s_cpu_gnt, s_vga_gnt, s_wren;
  int                cpu_gnt_total, wren_total, cpu_rv_total, vga_rv_total, cpu_rv_cyc;
  logic [DATA_W-1:0] cpu_rv_data;
  logic [DATA_W-1:0] cpu_seen[$], vga_seen[$];
  int                vga_cyc_q[$];

  int n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    denied      = 0;
    e_addr      = '0;
    e_wren      = 1'b0;
    e_wdata     = '0;
    e_cpu_rdata = '0;
    e_vga_rdata = '0;
    rd_q.delete();
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_vga(input bit req, input logic [ADDR_W-1:0] a);
    bus.vga_req = req; bus.vga_addr = a;
  endtask

  // One clock: compare every output at the falling edge, then advance the model.
  task automatic step();
    rd_t r;
    bit  e_cpu_rv, e_vga_rv;
    @(negedge clock);
    m_cpu = !reset && bus.cpu_req && (!bus.vga_req || denied >= CPU_MAX_WAIT);
    m_vga = !reset && bus.vga_req && !m_cpu;
    e_cpu_rv = 1'b0;
    e_vga_rv = 1'b0;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      r = rd_q.pop_front();
      if (r.owner == OWN_CPU) begin e_cpu_rv = 1'b1; e_cpu_rdata = r.data; end
      else begin e_vga_rv = 1'b1; e_vga_rdata = r.data; end
    end
    chk("cpu_gnt",     32'(bus.cpu_gnt),     32'(m_cpu));
    chk("vga_gnt",     32'(bus.vga_gnt),     32'(m_vga));
    chk("cpu_rvalid",  32'(bus.cpu_rvalid),  32'(e_cpu_rv));
    chk("vga_rvalid",  32'(bus.vga_rvalid),  32'(e_vga_rv));
    chk("cpu_rdata",   32'(bus.cpu_rdata),   32'(e_cpu_rdata));
    chk("vga_rdata",   32'(bus.vga_rdata),   32'(e_vga_rdata));
    chk("ram_wren",    32'(bus.ram_wren),    32'(e_wren));
    chk("ram_address", 32'(bus.ram_address), 32'(e_addr));
    chk("ram_data",    32'(bus.ram_data),    32'(e_wdata));
    chk("both_rvalid", 32'(bus.cpu_rvalid & bus.vga_rvalid), 32'(0));
    s_cpu_gnt = bus.cpu_gnt;
    s_vga_gnt = bus.vga_gnt;
    s_wren    = bus.ram_wren;
    if (bus.cpu_gnt)  cpu_gnt_total++;
    if (bus.ram_wren) wren_total++;
    if (bus.cpu_rvalid) begin
      cpu_rv_total++; cpu_rv_cyc = cyc; cpu_rv_data = bus.cpu_rdata;
      cpu_seen.push_back(bus.cpu_rdata);
    end
    if (bus.vga_rvalid) begin
      vga_rv_total++; vga_seen.push_back(bus.vga_rdata); vga_cyc_q.push_back(cyc);
    end
    if (m_cpu)
      $display("cyc %0d cpu %s addr=%h wdata=%h", cyc, bus.cpu_we ? "wr" : "rd",
               bus.cpu_addr, bus.cpu_wdata);
    if (m_vga) $display("cyc %0d vga rd addr=%h", cyc, bus.vga_addr);
    if (reset) begin
      model_reset();
    end else begin
      if (m_cpu) begin
        e_addr = bus.cpu_addr; e_wren = bus.cpu_we; e_wdata = bus.cpu_wdata;
        if (bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
        else rd_q.push_back('{due: cyc + RD_LAT + 1, owner: OWN_CPU, data: shadow[bus.cpu_addr]});
      end else if (m_vga) begin
        e_addr = bus.vga_addr; e_wren = 1'b0;
        rd_q.push_back('{due: cyc + RD_LAT + 1, owner: OWN_VGA, data: shadow[bus.vga_addr]});
      end else begin
        e_wren = 1'b0;
      end
      if (bus.cpu_req && !m_cpu) denied = (denied < CPU_MAX_WAIT) ? denied + 1 : denied;
      else denied = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    set_cpu(1'b0, 1'b0, '0, '0);
    set_vga(1'b0, '0);
    repeat (n) step();
  endtask

  vec_t tbl[15];
  int   g, n0, n1, n2, hit;

  initial begin
    // Expected grants for both-requesting streams and mixed patterns.
    tbl[0]  = '{1, 0, 1, 9'h000, 0, 1};
    tbl[1]  = '{1, 0, 1, 9'h000, 0, 1};
    tbl[2]  = '{1, 0, 1, 9'h000, 0, 1};
    tbl[3]  = '{1, 0, 1, 9'h000, 0, 1};
    tbl[4]  = '{1, 0, 1, 9'h000, 1, 0};
    tbl[5]  = '{1, 0, 1, 9'h000, 0, 1};
    tbl[6]  = '{0, 0, 1, 9'h000, 0, 1};
    tbl[7]  = '{1, 0, 0, 9'h000, 1, 0};
    tbl[8]  = '{0, 0, 0, 9'h000, 0, 0};
    tbl[9]  = '{1, 1, 0, 9'h0AA, 1, 0};
    tbl[10] = '{1, 0, 1, 9'h000, 0, 1};
    tbl[11] = '{1, 0, 1, 9'h000, 0, 1};
    tbl[12] = '{1, 0, 1, 9'h000, 0, 1};
    tbl[13] = '{1, 0, 1, 9'h000, 0, 1};
    tbl[14] = '{1, 0, 1, 9'h000, 1, 0};

    n_vec = 0; n_err = 0; cyc = 0;
    cpu_gnt_total = 0; wren_total = 0; cpu_rv_total = 0; vga_rv_total = 0; cpu_rv_cyc = -1;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram_mem[i] = DATA_W'(i);
      shadow[i]  = DATA_W'(i);
    end
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, '0, '0);
    set_vga(1'b0, '0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;

    // Requests during reset are never granted.
    set_cpu(1'b1, 1'b0, 16'h0020, '0);
    set_vga(1'b1, 16'h0001);
    step();
    chk("rst_cpu_gnt", 32'(s_cpu_gnt), 32'(0));
    chk("rst_vga_gnt", 32'(s_vga_gnt), 32'(0));
    reset = 1'b0;
    idle(1);

    // Arbitration table, CPU at 0x0020.
    for (int i = 0; i < 15; i++) begin
      set_cpu(tbl[i].cpu_req, tbl[i].cpu_we, 16'h0020, tbl[i].wdata);
      set_vga(tbl[i].vga_req, 16'(16'h0040 + i));
      step();
      chk($sformatf("tbl%0d_cpu_gnt", i), 32'(s_cpu_gnt), 32'(tbl[i].e_cpu));
      chk($sformatf("tbl%0d_vga_gnt", i), 32'(s_vga_gnt), 32'(tbl[i].e_vga));
    end
    idle(3);

    // CPU write then read-back of the same word.
    set_cpu(1'b1, 1'b1, 16'h0010, 9'h1A5);
    step();
    chk("wr_gnt", 32'(s_cpu_gnt), 32'(1));
    set_cpu(1'b1, 1'b0, 16'h0010, '0);
    g = cyc;
    step();
    chk("rd_gnt", 32'(s_cpu_gnt), 32'(1));
    chk("wr_wren", 32'(s_wren), 32'(1));
    idle(1);
    chk("rd_wren", 32'(s_wren), 32'(0));
    idle(RD_LAT + 1);
    chk("rd_latency", 32'(cpu_rv_cyc - g), 32'(RD_LAT + 1));
    chk("rd_data", 32'(cpu_rv_data), 32'(9'h1A5));

    // VGA stream of eight words, data = address.
    vga_seen.delete(); vga_cyc_q.delete();
    g = cyc;
    for (int i = 0; i < 8; i++) begin
      set_vga(1'b1, 16'(i));
      step();
    end
    idle(RD_LAT + 2);
    chk("stream_count", 32'(vga_seen.size()), 32'(8));
    if (vga_seen.size() == 8) begin
      chk("stream_first", 32'(vga_cyc_q[0] - g), 32'(RD_LAT + 1));
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("stream_data%0d", i), 32'(vga_seen[i]), 32'(i));
        chk($sformatf("stream_cyc%0d", i), 32'(vga_cyc_q[i] - vga_cyc_q[0]), 32'(i));
      end
    end

    // Contention routing between CPU @0x0001 and VGA @0x0002.
    set_cpu(1'b1, 1'b1, 16'h0001, 9'h011); step();
    set_cpu(1'b1, 1'b1, 16'h0002, 9'h022); step();
    cpu_seen.delete(); vga_seen.delete();
    for (int i = 0; i < 6; i++) begin
      set_cpu(i % 2 == 0, 1'b0, 16'h0001, '0);
      set_vga(i % 2 == 1, 16'h0002);
      step();
    end
    idle(RD_LAT + 2);
    chk("cont_cpu_count", 32'(cpu_seen.size()), 32'(3));
    chk("cont_vga_count", 32'(vga_seen.size()), 32'(3));
    foreach (cpu_seen[i]) chk("cont_cpu_data", 32'(cpu_seen[i]), 32'(9'h011));
    foreach (vga_seen[i]) chk("cont_vga_data", 32'(vga_seen[i]), 32'(9'h022));

    // Cancel: CPU write request withdrawn while VGA holds the port.
    n0 = cpu_gnt_total; n1 = wren_total; n2 = cpu_rv_total;
    set_vga(1'b1, 16'h0100);
    set_cpu(1'b1, 1'b1, 16'h0030, 9'h155);
    step(); step();
    set_cpu(1'b0, 1'b0, '0, '0);
    step(); step();
    chk("cancel_gnt", 32'(cpu_gnt_total - n0), 32'(0));
    chk("cancel_wren", 32'(wren_total - n1), 32'(0));
    chk("cancel_rvalid", 32'(cpu_rv_total - n2), 32'(0));
    hit = -1;
    set_cpu(1'b1, 1'b0, 16'h0030, '0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_cpu_gnt && hit < 0) hit = i;
    end
    chk("cancel_wait_clear", 32'(hit), 32'(4));
    idle(RD_LAT + 2);
    chk("cancel_no_write", 32'(cpu_rv_data), 32'(9'h030));

    // Reset right after a granted VGA read drops that read.
    set_vga(1'b1, 16'h0005);
    step();
    n0 = vga_rv_total;
    reset = 1'b1;
    set_vga(1'b0, '0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_vga_rvalid", 32'(bus.vga_rvalid), 32'(0));
    chk("post_rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(0));
    chk("post_rst_ram_address", 32'(bus.ram_address), 32'(0));
    chk("post_rst_ram_data", 32'(bus.ram_data), 32'(0));
    chk("post_rst_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
    chk("post_rst_vga_rdata", 32'(bus.vga_rdata), 32'(0));
    idle(3);
    chk("midflight_rvalid", 32'(vga_rv_total - n0), 32'(0));

    // Random traffic honouring the hold-until-grant rule, with rare resets.
    for (int i = 0; i < 300; i++) begin
      if (!bus.cpu_req || m_cpu) begin
        if ($urandom_range(0, 99) < 55)
          set_cpu(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
                  9'($urandom_range(0, 511)));
        else
          set_cpu(1'b0, 1'b0, '0, '0);
      end else if ($urandom_range(0, 99) < 8) begin
        bus.cpu_req = 1'b0;
      end
      set_vga($urandom_range(0, 99) < 60, 16'($urandom_range(0, 31)));
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    idle(RD_LAT + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single video RAM port between the CPU (read/write) and the VGA scanout (read-only pixel fetch). Performs one access per clock.
- VGA has fixed priority so it meets its pixel deadline. The CPU has a bounded-wait starvation guard.
- Returned read data is routed back to its owner through a tag pipeline matched to the RAM read latency.
- Sits between the CPU/VGA blocks and the RAM instance, in the VGA clock domain.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 9, RAM word width (3-bit R, G, B).
- RD_LAT, 1, RAM clock edges from a registered ram_address to a valid ram_q (1..3).
- CPU_MAX_WAIT, 4, consecutive denied CPU cycles after which the CPU wins arbitration.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  combinational grant; the access is accepted this cycle.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid.
- cpu_rdata  out  DATA_W  CPU read data (registered).
- vga_req  in  1  pixel fetch request.
- vga_addr  in  ADDR_W  pixel address.
- vga_gnt  out  1  combinational grant.
- vga_rvalid  out  1  one-cycle pulse; vga_rdata is valid.
- vga_rdata  out  DATA_W  pixel data (registered).
- ram_address  out  ADDR_W  registered RAM address.
- ram_wren  out  1  registered RAM write enable.
- ram_data  out  DATA_W  registered RAM write data.
- ram_q  in  DATA_W  RAM read data.

Behaviour:
- Reset: all outputs 0, wait counter 0, tag pipeline cleared.
  - In-flight reads at reset are dropped; no rvalid fires for them after reset.
- Arbitration (combinational, per cycle):
  - force = (wait_cnt == CPU_MAX_WAIT).
  - cpu_gnt = cpu_req & (~vga_req | force).
  - vga_gnt = vga_req & ~cpu_gnt.
  - At most one grant per cycle. Both grants are 0 while reset is high.
- Issue:
  - On a granted cycle, the next edge registers the owner's address into ram_address.
  - ram_wren = cpu_gnt & cpu_we.
  - ram_data = cpu_wdata when the CPU is granted, else holds its previous value.
  - With no grant: ram_wren = 0 and ram_address holds.
- Wait counter:
  - Increments when cpu_req & ~cpu_gnt, saturating at CPU_MAX_WAIT.
  - Clears on cpu_gnt or ~cpu_req.
  - Example with CPU_MAX_WAIT = 4 and both requesting continuously: the CPU is granted on its 5th request cycle, then VGA again, so the CPU gets 1 in 5 slots.
- Tag pipeline: depth RD_LAT+1, entries {valid, owner}.
  - Entry pushed = {granted read, owner}. CPU writes push valid = 0.
  - On stage-out, the owner's rdata is loaded from ram_q and its rvalid pulses for 1 cycle.
- Latency: rvalid is high exactly RD_LAT+1 cycles after the grant cycle. Back-to-back grants give back-to-back rvalids, in order, with no bubbles.
- Read-after-write: a CPU write granted at cycle t followed by any read granted at t+1 to the same address returns the new data. The RAM provides new-data read-during-write; the arbiter does not forward.
- The requester must hold addr/we/wdata while req & ~gnt. Deasserting req before grant cancels cleanly with no RAM side effect.
- rdata holds its last value between rvalid pulses.

Decomposition:
- Package vram_pkg holds:
  - owner_e enum {OWN_CPU, OWN_VGA}.
  - tag_t struct {logic valid; owner_e owner}.
  - Default ADDR_W and DATA_W constants.
- One sub-module, vram_tag_pipe: a parameterised RD_LAT+1-deep shift register of tag_t with synchronous clear.
- Arbitration, wait counter and issue registers stay in vram_arbiter.

Test Plan:
- Reset mid-flight: VGA read granted, reset asserted the next cycle → no vga_rvalid ever; all outputs 0 for the cycle after reset.
- CPU write then read: CPU writes 0x1A5 to 0x0010 (VGA idle), then reads 0x0010 → cpu_gnt both cycles, ram_wren = 1 only for the first, cpu_rvalid RD_LAT+1 cycles after the read grant with cpu_rdata = 0x1A5.
- VGA streaming: vga_req held for 8 cycles at addresses 0x0000..0x0007, RAM preloaded with data = addr → 8 consecutive vga_rvalid pulses, data 0..7 in order, starting RD_LAT+1 cycles after the first grant.
- Starvation guard: vga_req and cpu_req (read 0x0020) both held high, CPU_MAX_WAIT = 4 → cpu_gnt on the 5th cycle only; vga_gnt low that cycle and high on the other 4.
- Contention routing: alternating CPU read 0x0001 and VGA read 0x0002 (data 0x011, 0x022) → each rvalid fires only on the correct owner with the matching data; never both rvalids in the same cycle.
- Cancel: cpu_req high for 2 cycles while VGA holds the port, then dropped → no cpu_gnt, no ram_wren, no cpu_rvalid, wait counter back to 0.
